// File: rtl/nn_image_loader.sv
// Input stage of the digit-recognition pipeline: collects a raster-order grayscale frame from a
// valid/ready byte stream, presents it to the network, then restarts and enables the network until done.
module nn_image_loader #(
    parameter  int IMG_W = 28,
    parameter  int IMG_H = 28,
    parameter  int PIX_W = 8,
    localparam int N_PIX = IMG_W * IMG_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [PIX_W-1:0] img_out [0:N_PIX-1],
    output logic             nn_reset,
    output logic             nn_enable,
    input  logic             nn_done,
    output logic [15:0]      frame_count,
    output logic             sof_error
);

    localparam int               IDX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic             accept_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] wr_addr_s;

    // Ready depends only on the state so upstream never sees a valid->ready loop.
    always_comb begin
        pix_ready = 1'b0;
        case (state_r)
            ST_IDLE: pix_ready = 1'b1;
            ST_LOAD: pix_ready = 1'b1;
            default: pix_ready = 1'b0;
        endcase
    end

    assign accept_s = pix_valid & pix_ready;

    // Write decode: an SOF always restarts at pixel 0; plain pixels only land while loading.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = idx_r;
        if (accept_s) begin
            if (pix_sof) begin
                wr_en_s   = 1'b1;
                wr_addr_s = IDX_ZERO;
            end else begin
                wr_en_s   = (state_r == ST_LOAD);
                wr_addr_s = idx_r;
            end
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = idx_r;
        end
    end

    // Frame storage doubles as the network image register; deliberately never cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            img_out[wr_addr_s] <= pix_in;
        end
    end

    // Frame sequencer: LOAD -> ARM (one restart pulse) -> RUN (enable until the network reports done).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            nn_reset    <= 1'b0;
            nn_enable   <= 1'b0;
            sof_error   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            nn_reset  <= 1'b0;
            sof_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && pix_sof) begin
                        idx_r   <= IDX_ONE;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        if (pix_sof) begin
                            // Early SOF abandons the partial frame and restarts in place.
                            idx_r     <= IDX_ONE;
                            sof_error <= 1'b1;
                        end else if (idx_r == LAST_IDX) begin
                            idx_r    <= IDX_ZERO;
                            nn_reset <= 1'b1;
                            state_r  <= ST_ARM;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                ST_ARM: begin
                    nn_enable <= 1'b1;
                    state_r   <= ST_RUN;
                end
                ST_RUN: begin
                    if (nn_done) begin
                        nn_enable   <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    nn_enable <= 1'b0;
                    idx_r     <= IDX_ZERO;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
